stream_demux4: RTL and testbench
================================

# stream_demux4

Registered 1-to-4 stream demultiplexer: the distribution side of the 4:1 selection path. One input word stream is routed to one of four output channels, chosen either by an external select or by an internal auto-advancing pointer. Each channel has a one-entry holding register with valid/ready handshake. It sits upstream of per-channel consumers that feed the team's 4:1 multiplexer back into a single stream.

## Interface
- Width, 8, data word width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  Width  input word
- in_valid  input  1  input word present
- in_ready  output  1  block accepts in_data this cycle
- mode_auto  input  1  1: route by internal pointer; 0: route by counter_sel
- counter_sel  input  2  manual channel select (0..3)
- auto_ptr  output  2  current internal pointer value
- out_data  output  4*Width  channel i data at bits [i*Width +: Width]
- out_valid  output  4  channel i holds a word
- out_ready  input  4  channel i consumer takes word this cycle

## Operation
- eff_sel = mode_auto ? auto_ptr : counter_sel (combinational).
- Each channel slot is a 2-state machine, EMPTY/FULL, with out_valid[i] = (state == FULL).
- in_ready = !out_valid[eff_sel] | out_ready[eff_sel]. This is combinational and passes through on a same-cycle drain.
- Accept = in_valid & in_ready. On accept, slot eff_sel loads in_data and is FULL next cycle.
- Drain of slot i = out_valid[i] & out_ready[i]. Slot i goes EMPTY unless it is loaded in the same cycle; in that case it stays FULL with the new data.
- Non-selected slots are unaffected by input traffic. Each drains independently.
- auto_ptr advances by 1 on each accept, only while mode_auto = 1. It wraps 3 → 0. While mode_auto = 0 it holds its value.
- Mode change takes effect in the same cycle for eff_sel. auto_ptr is not reset by a mode change.
- Producer rules: once in_valid is high, in_data, counter_sel and mode_auto must stay stable until accept. The bench checks this; the DUT does not.
- No word is ever dropped or duplicated. Slots never overwrite while FULL without a drain.

## Timing
- Latency: a word accepted at cycle N is visible on out_data/out_valid at cycle N+1.
- Throughput: one word per cycle into any channel whose consumer holds out_ready high.
- Reset (rst_n = 0 at a clock edge):
  - all slots go EMPTY, out_valid = 4'b0000
  - out_data = 0
  - auto_ptr = 0
  - in_ready = 1 in the following cycle
- Reset mid-operation discards all held words. No output handshake completes on the reset edge.
- out_data[i] holds its value while slot i is FULL and not drained. After a drain the data is don't-care but must be stable, i.e. the register is held, not cleared.
- Boundary cases:
  - selected slot FULL with out_ready low: in_ready = 0, auto_ptr holds.
  - selected slot FULL with out_ready high: load and drain in the same cycle, out_valid stays 1.
  - auto wrap: after 4 accepts starting from auto_ptr = 0, auto_ptr = 0 again.

## Structure
- The shared package holds:
  - NUM_CH = 4, SEL_W = 2
  - typedef ch_sel_t (logic [SEL_W-1:0])
  - slot state enum {EMPTY, FULL}
- Sub-module demux_slot, parameterised by Width, instantiated NUM_CH times.
  - Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data.
  - Implements the EMPTY/FULL register slice.
- Top level holds:
  - eff_sel mux
  - in_ready generation
  - load decode (one-hot of eff_sel gated by accept)
  - auto_ptr counter

## Test plan
- Reset: rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0000, auto_ptr = 0, no accept. in_ready = 1 in the first cycle after release.
- Manual routing: mode_auto = 0, counter_sel = 2, in_data = 8'hA5, all out_ready = 1 → next cycle out_valid = 0100 and out_data[23:16] = 8'hA5. The cycle after, out_valid = 0000.
- Auto round-robin: mode_auto = 1, four back-to-back words 8'h10..8'h13, out_ready = 0000 → out_valid = 1111, channel i holds 8'h10+i, auto_ptr = 0. A fifth word sees in_ready = 0.
- Backpressure and pass-through:
  - Channel 1 FULL with 8'h11, out_ready[1] = 0, counter_sel = 1 → in_ready = 0 and data is held.
  - Raise out_ready[1] with a new word 8'h22 → same-cycle accept; next cycle out_valid[1] = 1 with 8'h22.
- Mode switch: auto_ptr = 3, switch to mode_auto = 0, send 2 words to channel 0 → auto_ptr stays 3. Back in auto mode, the next word lands in channel 3, then auto_ptr = 0.
- Reset mid-stream: channels 0 and 2 FULL, assert rst_n = 0 for 1 cycle → out_valid = 0000, auto_ptr = 0, and the held words never appear.

Source files
------------

// File: rtl/stream_demux4_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer: channel count, select width, slot states.
package stream_demux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/stream_demux4_slot.sv
// One-entry output holding register; a load takes priority and refills a slot that drains in the same cycle.
// Data is held after a drain so the output stays stable until the next load.
module demux_slot
  import stream_demux4_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  slot_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
    end else if (load) begin
      state    <= FULL;
      out_data <= load_data;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: rtl/stream_demux4.sv
// Registered 1-to-4 stream demux, routed by external select or an auto-advancing pointer.
// One cycle latency; in_ready follows the selected slot and passes through a same-cycle drain.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Width-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode_auto,
  input  logic [SEL_W-1:0]    counter_sel,
  output logic [SEL_W-1:0]    auto_ptr,
  output logic [4*Width-1:0]  out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready
);

  ch_sel_t           eff_sel;
  logic              accept;
  logic [NUM_CH-1:0] load;

  assign eff_sel  = mode_auto ? auto_ptr : counter_sel;
  assign in_ready = !out_valid[eff_sel] || out_ready[eff_sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = accept && (eff_sel == ch_sel_t'(i));
    end
  end

  // Pointer only moves on accepts taken while in auto mode; a mode switch leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_ptr <= '0;
    end else if (accept && mode_auto) begin
      auto_ptr <= auto_ptr + ch_sel_t'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.Width(Width)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*Width +: Width])
    );
  end

endmodule

// File: tb/tb_stream_demux4.sv
// Directed-vector bench for stream_demux4; inputs change 1 time unit after a rising edge and are checked there.
module tb_stream_demux4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode_auto;
  logic [1:0]  counter_sel;
  logic [1:0]  auto_ptr;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int checks = 0;
  int errors = 0;

  stream_demux4 #(.Width(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode_auto   (mode_auto),
    .counter_sel (counter_sel),
    .auto_ptr    (auto_ptr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch(input int i);
    return out_data[i*8 +: 8];
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    mode_auto = 1'b0; counter_sel = 2'd0; out_ready = 4'b0000;
    #1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_auto_ptr", 32'(auto_ptr), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Manual routing to channel 2
    mode_auto = 1'b0; counter_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b1111;
    #1;
    chk("man_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("man_valid", 32'(out_valid), 32'h4);
    chk("man_data", 32'(ch(2)), 32'hA5);
    tick();
    chk("man_drained", 32'(out_valid), 32'h0);
    chk("man_data_held", 32'(ch(2)), 32'hA5);
    chk("man_ptr", 32'(auto_ptr), 32'h0);

    // Auto round-robin with all consumers stalled
    mode_auto = 1'b1; out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h10 + 8'(k); in_valid = 1'b1;
      #1;
      chk("rr_ptr", 32'(auto_ptr), 32'(k));
      tick();
    end
    in_data = 8'h14;
    chk("rr_full", 32'(out_valid), 32'hF);
    chk("rr_wrap", 32'(auto_ptr), 32'h0);
    chk("rr_data", out_data, 32'h13121110);
    chk("rr_fifth_blocked", 32'(in_ready), 32'h0);
    tick();
    chk("rr_fifth_held", out_data, 32'h13121110);
    chk("rr_ptr_hold", 32'(auto_ptr), 32'h0);
    in_valid = 1'b0;

    // Backpressure then same-cycle drain and reload on channel 1
    mode_auto = 1'b0; counter_sel = 2'd1;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("bp_data_held", 32'(ch(1)), 32'h11);
    out_ready = 4'b0010; in_data = 8'h22; in_valid = 1'b1;
    #1;
    chk("pt_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("pt_valid", 32'(out_valid), 32'hF);
    chk("pt_data", 32'(ch(1)), 32'h22);
    chk("pt_ptr", 32'(auto_ptr), 32'h0);

    // Mode switch: bring pointer to 3, send two manual words, then resume auto
    out_ready = 4'b1111;
    tick();
    chk("ms_drain_all", 32'(out_valid), 32'h0);
    mode_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h30 + 8'(k); in_valid = 1'b1;
      tick();
    end
    chk("ms_ptr3", 32'(auto_ptr), 32'h3);
    mode_auto = 1'b0; counter_sel = 2'd0;
    in_data = 8'h40; tick();
    in_data = 8'h41; tick();
    chk("ms_ptr_held", 32'(auto_ptr), 32'h3);
    chk("ms_ch0", 32'(ch(0)), 32'h41);
    mode_auto = 1'b1; in_data = 8'h50;
    #1;
    chk("ms_auto_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("ms_valid", 32'(out_valid), 32'h8);
    chk("ms_ch3", 32'(ch(3)), 32'h50);
    chk("ms_ptr_wrap", 32'(auto_ptr), 32'h0);
    tick();
    chk("ms_drained", 32'(out_valid), 32'h0);

    // Reset mid-stream with channels 0 and 2 full
    out_ready = 4'b0000;
    mode_auto = 1'b1; in_data = 8'h60; in_valid = 1'b1;
    tick();
    mode_auto = 1'b0; counter_sel = 2'd2; in_data = 8'h62;
    tick();
    in_valid = 1'b0;
    chk("mr_pre_valid", 32'(out_valid), 32'h5);
    chk("mr_pre_ptr", 32'(auto_ptr), 32'h1);
    rst_n = 1'b0; out_ready = 4'b1111;
    tick();
    rst_n = 1'b1; out_ready = 4'b0000;
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_ptr", 32'(auto_ptr), 32'h0);
    chk("mr_data", out_data, 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'h1);
    tick(); tick();
    chk("mr_no_reappear", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
